req_dispatch: RTL and testbench

//  Request-side counterpart of the response output mux: takes one calc1-style request port
//  (cmd+op1 in cycle N, op2 in cycle N+1) and routes each command to one of two execution units.
//  add/sub -> unit 0 (ALU), shl/shr -> unit 1 (shifter); per-unit FIFO buffering with valid/ready.

---
 rtl/req_dispatch_if.sv | 49 ++++
 rtl/req_dispatch.sv | 178 +++++++++++++++++
 tb/tb_req_dispatch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/req_dispatch_if.sv
// Request port plus the two unit ports and the invalid-response side channel of the dispatcher.
interface req_dispatch_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 2
);
   // request side: cmd+op1 in the cmd cycle, op2 in the following cycle
   logic [3:0]        req_cmd_in;
   logic [DATA_W-1:0] req_data_in;
   logic [TAG_W-1:0]  req_tag_in;
   logic              req_ready;

   // unit 0 (ALU: add/sub)
   logic              u0_valid;
   logic [3:0]        u0_cmd;
   logic [DATA_W-1:0] u0_data1;
   logic [DATA_W-1:0] u0_data2;
   logic [TAG_W-1:0]  u0_tag;
   logic              u0_ready;

   // unit 1 (shifter: shl/shr)
   logic              u1_valid;
   logic [3:0]        u1_cmd;
   logic [DATA_W-1:0] u1_data1;
   logic [DATA_W-1:0] u1_data2;
   logic [TAG_W-1:0]  u1_tag;
   logic              u1_ready;

   // invalid-command response towards the response mux
   logic [1:0]        inv_resp;
   logic [TAG_W-1:0]  inv_tag;

   // environment side: issues requests and consumes unit heads
   modport master (
      output req_cmd_in, req_data_in, req_tag_in, u0_ready, u1_ready,
      input  req_ready,
      input  u0_valid, u0_cmd, u0_data1, u0_data2, u0_tag,
      input  u1_valid, u1_cmd, u1_data1, u1_data2, u1_tag,
      input  inv_resp, inv_tag
   );

   // dispatcher side
   modport slave (
      input  req_cmd_in, req_data_in, req_tag_in, u0_ready, u1_ready,
      output req_ready,
      output u0_valid, u0_cmd, u0_data1, u0_data2, u0_tag,
      output u1_valid, u1_cmd, u1_data1, u1_data2, u1_tag,
      output inv_resp, inv_tag
   );
endinterface

// File: rtl/req_dispatch.sv
// Request dispatcher: collects a two-cycle request (cmd+op1, then op2) and queues it to the
// ALU (add/sub) or shifter (shl/shr) unit FIFO; invalid commands produce a one-cycle invalid response.
module req_dispatch #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TAG_W      = 2,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic          c_clk,
   input  logic          reset,
   req_dispatch_if.slave bus
);

   localparam int unsigned NUM_UNITS = 2;
   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   typedef struct packed {
      logic [3:0]        cmd;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   typedef enum logic {
      ST_IDLE,
      ST_OP2
   } state_t;

   state_t                 state_q, state_nxt;
   logic                   capture;
   logic [NUM_UNITS-1:0]   push;
   logic                   inv_hit;
   logic                   req_ready_c;
   logic [NUM_UNITS-1:0]   unit_ready;
   entry_t                 new_entry;

   logic [3:0]             cmd_q;
   logic [DATA_W-1:0]      op1_q;
   logic [TAG_W-1:0]       tag_q;
   logic [1:0]             inv_resp_q;
   logic [TAG_W-1:0]       inv_tag_q;

   assign unit_ready = {bus.u1_ready, bus.u0_ready};
   assign new_entry  = {cmd_q, op1_q, bus.req_data_in, tag_q};

   // Acceptance needs IDLE and room in both FIFOs, so the entry is always placeable two cycles later.
   assign req_ready_c = !reset && (state_q == ST_IDLE)
                        && (g_unit[0].count_q < DEPTH_C)
                        && (g_unit[1].count_q < DEPTH_C);
   assign bus.req_ready = req_ready_c;

   // State register.
   always_ff @(posedge c_clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   // Next state, capture strobe, FIFO push and invalid-command decode.
   always_comb begin
      state_nxt = state_q;
      capture   = 1'b0;
      push      = '0;
      inv_hit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_ready_c && (bus.req_cmd_in != CMD_NOP)) begin
               capture   = 1'b1;
               state_nxt = ST_OP2;
            end
         end
         ST_OP2: begin
            state_nxt = ST_IDLE;
            case (cmd_q)
               CMD_ADD, CMD_SUB: push[0] = 1'b1;
               CMD_SHL, CMD_SHR: push[1] = 1'b1;
               default:          inv_hit = 1'b1;
            endcase
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Latch cmd, op1 and tag in the cmd cycle.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         cmd_q <= '0;
         op1_q <= '0;
         tag_q <= '0;
      end else if (capture) begin
         cmd_q <= bus.req_cmd_in;
         op1_q <= bus.req_data_in;
         tag_q <= bus.req_tag_in;
      end
   end

   // One-cycle invalid response; the tag is held until the next invalid command.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         inv_resp_q <= 2'b00;
         inv_tag_q  <= '0;
      end else begin
         inv_resp_q <= inv_hit ? 2'b10 : 2'b00;
         if (inv_hit) inv_tag_q <= tag_q;
      end
   end

   assign bus.inv_resp = inv_resp_q;
   assign bus.inv_tag  = inv_tag_q;

   // Per-unit FIFO with a registered head stage mirroring the entry at the read pointer.
   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
      entry_t            mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q;
      logic [PTR_W-1:0]  rd_ptr_q;
      logic [PTR_W-1:0]  rd_nxt;
      logic [CNT_W-1:0]  count_q;
      logic [CNT_W-1:0]  count_nxt;
      entry_t            head_q;
      entry_t            head_nxt;
      logic              valid_q;
      logic              pop;

      // Next count/read pointer and the entry that becomes the head after this edge.
      always_comb begin
         pop       = valid_q && unit_ready[u];
         count_nxt = count_q + CNT_W'(push[u]) - CNT_W'(pop);
         rd_nxt    = rd_ptr_q + PTR_W'(pop);
         head_nxt  = head_q;
         if (count_nxt != '0) begin
            // the entry being written becomes head only when it will be the sole occupant
            if (push[u] && (wr_ptr_q == rd_nxt)) head_nxt = new_entry;
            else                                 head_nxt = mem[rd_nxt];
         end
      end

      // Storage array, written at the write pointer.
      always_ff @(posedge c_clk) begin
         if (!reset && push[u]) mem[wr_ptr_q] <= new_entry;
      end

      // Pointers, occupancy and head registers.
      always_ff @(posedge c_clk) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push[u]);
            rd_ptr_q <= rd_nxt;
            count_q  <= count_nxt;
            head_q   <= head_nxt;
            valid_q  <= (count_nxt != '0);
         end
      end
   end

   assign bus.u0_valid = g_unit[0].valid_q;
   assign bus.u0_cmd   = g_unit[0].head_q.cmd;
   assign bus.u0_data1 = g_unit[0].head_q.op1;
   assign bus.u0_data2 = g_unit[0].head_q.op2;
   assign bus.u0_tag   = g_unit[0].head_q.tag;

   assign bus.u1_valid = g_unit[1].valid_q;
   assign bus.u1_cmd   = g_unit[1].head_q.cmd;
   assign bus.u1_data1 = g_unit[1].head_q.op1;
   assign bus.u1_data2 = g_unit[1].head_q.op2;
   assign bus.u1_tag   = g_unit[1].head_q.tag;

endmodule

// File: tb/tb_req_dispatch.sv
// Bench for req_dispatch: directed scenarios followed by random traffic, all checked every cycle
// against a queue-based transaction model of the dispatcher.
module tb_req_dispatch;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned TAG_W      = 2;
   localparam int unsigned FIFO_DEPTH = 2;

   logic c_clk = 1'b0;
   logic reset;

   always #5 c_clk = ~c_clk;

   req_dispatch_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   req_dispatch #(
      .DATA_W     (DATA_W),
      .TAG_W      (TAG_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .c_clk (c_clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [1:0]  tag;
   } txn_t;

   // model: queued transactions per unit, plus the half-received request and pending invalid response
   txn_t        q0[$];
   txn_t        q1[$];
   bit          m_busy;
   logic [3:0]  m_cmd;
   logic [31:0] m_op1;
   logic [1:0]  m_tag;
   bit          m_inv;
   logic [1:0]  m_inv_tag;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic bit model_ready();
      return !reset && !m_busy && (q0.size() < int'(FIFO_DEPTH)) && (q1.size() < int'(FIFO_DEPTH));
   endfunction

   // Compare every DUT output with what the model says is visible this cycle.
   task automatic check_outputs();
      check_eq("req_ready", 64'(bus.req_ready), 64'(model_ready()));
      check_eq("u0_valid", 64'(bus.u0_valid), 64'(q0.size() != 0));
      if (q0.size() != 0) begin
         check_eq("u0_cmd",   64'(bus.u0_cmd),   64'(q0[0].cmd));
         check_eq("u0_data1", 64'(bus.u0_data1), 64'(q0[0].op1));
         check_eq("u0_data2", 64'(bus.u0_data2), 64'(q0[0].op2));
         check_eq("u0_tag",   64'(bus.u0_tag),   64'(q0[0].tag));
      end
      check_eq("u1_valid", 64'(bus.u1_valid), 64'(q1.size() != 0));
      if (q1.size() != 0) begin
         check_eq("u1_cmd",   64'(bus.u1_cmd),   64'(q1[0].cmd));
         check_eq("u1_data1", 64'(bus.u1_data1), 64'(q1[0].op1));
         check_eq("u1_data2", 64'(bus.u1_data2), 64'(q1[0].op2));
         check_eq("u1_tag",   64'(bus.u1_tag),   64'(q1[0].tag));
      end
      check_eq("inv_resp", 64'(bus.inv_resp), m_inv ? 64'd2 : 64'd0);
      if (m_inv) check_eq("inv_tag", 64'(bus.inv_tag), 64'(m_inv_tag));
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_edge();
      bit   rdy;
      txn_t t;
      rdy = model_ready();
      if (reset) begin
         q0.delete();
         q1.delete();
         m_busy = 1'b0;
         m_inv  = 1'b0;
         return;
      end
      m_inv = 1'b0;
      if (q0.size() != 0 && bus.u0_ready) q0.delete(0);
      if (q1.size() != 0 && bus.u1_ready) q1.delete(0);
      if (m_busy) begin
         m_busy = 1'b0;
         t.cmd = m_cmd; t.op1 = m_op1; t.op2 = bus.req_data_in; t.tag = m_tag;
         if (m_cmd == 4'd1 || m_cmd == 4'd2)      q0.push_back(t);
         else if (m_cmd == 4'd5 || m_cmd == 4'd6) q1.push_back(t);
         else begin
            m_inv     = 1'b1;
            m_inv_tag = m_tag;
         end
      end else if (rdy && bus.req_cmd_in != 4'd0) begin
         m_busy = 1'b1;
         m_cmd  = bus.req_cmd_in;
         m_op1  = bus.req_data_in;
         m_tag  = bus.req_tag_in;
      end
   endtask

   // One clock: drive inputs at the falling edge, check, step the model, advance to the next falling edge.
   task automatic cycle(input logic [3:0] cmd, input logic [31:0] data, input logic [1:0] tag,
                        input logic r0, input logic r1, input logic rst);
      bus.req_cmd_in  = cmd;
      bus.req_data_in = data;
      bus.req_tag_in  = tag;
      bus.u0_ready    = r0;
      bus.u1_ready    = r1;
      reset           = rst;
      #1;
      check_outputs();
      model_edge();
      @(posedge c_clk);
      @(negedge c_clk);
   endtask

   initial begin
      logic [3:0] rc;
      int         pick;

      bus.req_cmd_in  = 4'd0;
      bus.req_data_in = 32'd0;
      bus.req_tag_in  = 2'd0;
      bus.u0_ready    = 1'b0;
      bus.u1_ready    = 1'b0;
      reset           = 1'b1;
      m_busy = 1'b0; m_inv = 1'b0; m_cmd = 4'd0; m_op1 = 32'd0; m_tag = 2'd0; m_inv_tag = 2'd0;
      @(negedge c_clk);
      @(negedge c_clk);

      // reset state
      check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check_eq("rst_u0_valid",  64'(bus.u0_valid),  64'd0);
      check_eq("rst_u1_valid",  64'(bus.u1_valid),  64'd0);
      check_eq("rst_u0_cmd",    64'(bus.u0_cmd),    64'd0);
      check_eq("rst_u0_data1",  64'(bus.u0_data1),  64'd0);
      check_eq("rst_u1_tag",    64'(bus.u1_tag),    64'd0);
      check_eq("rst_inv_resp",  64'(bus.inv_resp),  64'd0);
      check_eq("rst_inv_tag",   64'(bus.inv_tag),   64'd0);

      // add routed to unit 0, visible two cycles after the cmd cycle
      cycle(4'd1, 32'd4096, 2'd1, 1'b1, 1'b1, 1'b0);
      cycle(4'd0, 32'd1234, 2'd0, 1'b1, 1'b1, 1'b0);
      check_eq("t1_u0_valid", 64'(bus.u0_valid), 64'd1);
      check_eq("t1_u0_cmd",   64'(bus.u0_cmd),   64'd1);
      check_eq("t1_u0_data1", 64'(bus.u0_data1), 64'd4096);
      check_eq("t1_u0_data2", 64'(bus.u0_data2), 64'd1234);
      check_eq("t1_u0_tag",   64'(bus.u0_tag),   64'd1);
      check_eq("t1_u1_valid", 64'(bus.u1_valid), 64'd0);

      // shl routed to unit 1
      cycle(4'd5, 32'h1, 2'd2, 1'b1, 1'b1, 1'b0);
      cycle(4'd0, 32'd4, 2'd0, 1'b1, 1'b1, 1'b0);
      check_eq("t2_u1_valid", 64'(bus.u1_valid), 64'd1);
      check_eq("t2_u1_cmd",   64'(bus.u1_cmd),   64'd5);
      check_eq("t2_u1_data1", 64'(bus.u1_data1), 64'd1);
      check_eq("t2_u1_data2", 64'(bus.u1_data2), 64'd4);
      check_eq("t2_u1_tag",   64'(bus.u1_tag),   64'd2);
      check_eq("t2_u0_valid", 64'(bus.u0_valid), 64'd0);

      // invalid cmd: one-cycle response, nothing queued
      cycle(4'd3, 32'd7, 2'd3, 1'b1, 1'b1, 1'b0);
      cycle(4'd0, 32'd8, 2'd0, 1'b1, 1'b1, 1'b0);
      check_eq("t3_inv_resp", 64'(bus.inv_resp), 64'd2);
      check_eq("t3_inv_tag",  64'(bus.inv_tag),  64'd3);
      check_eq("t3_u0_valid", 64'(bus.u0_valid), 64'd0);
      check_eq("t3_u1_valid", 64'(bus.u1_valid), 64'd0);
      cycle(4'd0, 32'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      check_eq("t3_inv_drop", 64'(bus.inv_resp), 64'd0);

      // fill unit 0 with a stalled consumer, then release one entry
      cycle(4'd1, 32'd11, 2'd0, 1'b0, 1'b0, 1'b0);
      cycle(4'd0, 32'd12, 2'd0, 1'b0, 1'b0, 1'b0);
      cycle(4'd2, 32'd21, 2'd1, 1'b0, 1'b0, 1'b0);
      cycle(4'd0, 32'd22, 2'd0, 1'b0, 1'b0, 1'b0);
      check_eq("t4_full_ready", 64'(bus.req_ready), 64'd0);
      check_eq("t4_head_data1", 64'(bus.u0_data1),  64'd11);
      cycle(4'd1, 32'd99, 2'd2, 1'b0, 1'b0, 1'b0);
      check_eq("t4_full_hold",  64'(bus.req_ready), 64'd0);
      cycle(4'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t4_ready_back", 64'(bus.req_ready), 64'd1);
      check_eq("t4_next_cmd",   64'(bus.u0_cmd),    64'd2);
      check_eq("t4_next_data1", 64'(bus.u0_data1),  64'd21);
      check_eq("t4_next_data2", 64'(bus.u0_data2),  64'd22);
      cycle(4'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t4_drained", 64'(bus.u0_valid), 64'd0);

      // push and pop on the same edge with one entry queued
      cycle(4'd1, 32'd31, 2'd0, 1'b0, 1'b0, 1'b0);
      cycle(4'd0, 32'd32, 2'd0, 1'b0, 1'b0, 1'b0);
      cycle(4'd2, 32'd41, 2'd3, 1'b0, 1'b0, 1'b0);
      cycle(4'd0, 32'd42, 2'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t5_valid", 64'(bus.u0_valid),  64'd1);
      check_eq("t5_data1", 64'(bus.u0_data1),  64'd41);
      check_eq("t5_data2", 64'(bus.u0_data2),  64'd42);
      check_eq("t5_ready", 64'(bus.req_ready), 64'd1);
      cycle(4'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      check_eq("t5_drained", 64'(bus.u0_valid), 64'd0);

      // reset during the op2 cycle drops the request
      cycle(4'd2, 32'd51, 2'd1, 1'b1, 1'b1, 1'b0);
      cycle(4'd0, 32'd52, 2'd0, 1'b1, 1'b1, 1'b1);
      check_eq("t6_u0_valid", 64'(bus.u0_valid),  64'd0);
      check_eq("t6_u0_cmd",   64'(bus.u0_cmd),    64'd0);
      check_eq("t6_inv_resp", 64'(bus.inv_resp),  64'd0);
      check_eq("t6_ready_rst", 64'(bus.req_ready), 64'd0);
      cycle(4'd0, 32'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      check_eq("t6_ready_after", 64'(bus.req_ready), 64'd1);
      check_eq("t6_u0_after",    64'(bus.u0_valid),  64'd0);

      // random traffic: mixed commands, back-pressure and occasional reset
      for (int i = 0; i < 3000; i++) begin
         pick = int'($urandom_range(0, 9));
         case (pick)
            0: rc = 4'd0;
            1: rc = 4'd1;
            2: rc = 4'd2;
            3: rc = 4'd5;
            4: rc = 4'd6;
            5: rc = 4'd1;
            6: rc = 4'd6;
            default: rc = 4'($urandom_range(0, 15));
         endcase
         cycle(rc, $urandom, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 299) == 0));
      end
      for (int i = 0; i < 6; i++) cycle(4'd0, 32'd0, 2'd0, 1'b1, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
